// File: rtl/prbs_pkg.sv
// Purpose: shared PRBS-26 definitions: checker FSM states, register length, feedback taps, predictor.
// Latency: none (types, constants and one combinational helper).
// Backpressure: not applicable.
package prbs_pkg;

   typedef enum logic {
      HUNT  = 1'b0,
      CHECK = 1'b1
   } state_t;

   localparam int PRBS_WIDTH = 26;

   // Feedback taps of x^26+x^6+x^2+x+1, as delays: b[n] depends on b[n-TAP].
   localparam int TAP_A = 20;
   localparam int TAP_B = 24;
   localparam int TAP_C = 25;
   localparam int TAP_D = 26;

   // History is kept newest-first: h[k-1] holds b[n-k].
   function automatic logic prbs_next(input logic [PRBS_WIDTH-1:0] h);
      return h[TAP_A-1] ^ h[TAP_B-1] ^ h[TAP_C-1] ^ h[TAP_D-1];
   endfunction

endpackage

// File: rtl/prbs_lock_mon.sv
// Purpose: loss-of-lock monitor; counts checked bits and errors per fixed window.
// Latency: lose_lock is combinational on the errored bit that reaches the threshold.
// Backpressure: none; only counts on cycles where a bit is actually checked.
import prbs_pkg::*;

module prbs_lock_mon #(
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic check_bit,
   input  logic mismatch,
   output logic lose_lock
);

   localparam int WC_W = $clog2(WINDOW + 1);
   localparam int EC_W = $clog2(LOSS_THRESH + 1);

   logic [WC_W-1:0] win_cnt;
   logic [EC_W-1:0] win_err;
   logic            win_end;

   assign win_end   = (win_cnt == WC_W'(WINDOW - 1));
   assign lose_lock = check_bit && mismatch && (win_err == EC_W'(LOSS_THRESH - 1));

   // Window bit/error counters; both restart at a window boundary or when lock is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (check_bit) begin
         if (lose_lock || win_end) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + WC_W'(1);
            if (mismatch) begin
               win_err <= win_err + EC_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// Purpose: PRBS-26 serial checker; hunts for lock, then predicts and compares each bit. Macro PRBS_CHECKER_BITCNT_EN builds bit_cnt.
// Latency: err_pulse/locked/counters update on the edge sampling the bit, visible the next cycle.
// Backpressure: none; din is sampled only when din_valid is high, otherwise everything holds.
import prbs_pkg::*;

module prbs_checker #(
   parameter int WIDTH       = PRBS_WIDTH,
   parameter int ERR_W       = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [31:0]      bit_cnt
);

   localparam int FILL_W = $clog2(WIDTH + 1);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  hist, hist_nxt;
   logic [FILL_W-1:0] fill, fill_nxt;
   logic              pred;
   logic              check_bit;
   logic              mismatch;
   logic              err;
   logic              lose_lock;

   assign pred      = prbs_next(hist[PRBS_WIDTH-1:0]);
   assign check_bit = din_valid && (state == CHECK);
   assign mismatch  = din ^ pred;
   assign err       = check_bit && mismatch;

   prbs_lock_mon #(
      .WINDOW      (WINDOW),
      .LOSS_THRESH (LOSS_THRESH)
   ) u_lock_mon (
      .clk       (clk),
      .rst       (rst),
      .check_bit (check_bit),
      .mismatch  (mismatch),
      .lose_lock (lose_lock)
   );

   // Next state, history and fill count; while locked the prediction (not din) feeds the history.
   always_comb begin
      state_nxt = state;
      hist_nxt  = hist;
      fill_nxt  = fill;
      if (din_valid) begin
         case (state)
            HUNT: begin
               hist_nxt = {hist[WIDTH-2:0], din};
               if (fill == FILL_W'(WIDTH - 1)) begin
                  fill_nxt = '0;
                  if (hist_nxt != '0) begin
                     state_nxt = CHECK;
                  end
               end else begin
                  fill_nxt = fill + FILL_W'(1);
               end
            end
            CHECK: begin
               hist_nxt = {hist[WIDTH-2:0], pred};
               if (lose_lock) begin
                  state_nxt = HUNT;
                  fill_nxt  = '0;
               end
            end
            default: begin
               state_nxt = HUNT;
               fill_nxt  = '0;
            end
         endcase
      end
   end

   // State register plus registered lock and error-pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HUNT;
         hist      <= '0;
         fill      <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         hist      <= hist_nxt;
         fill      <= fill_nxt;
         locked    <= (state_nxt == CHECK);
         err_pulse <= err;
      end
   end

   // Saturating error counter; clr wins over a coincident error.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_cnt <= '0;
      end else if (err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

`ifdef PRBS_CHECKER_BITCNT_EN
   // Saturating count of bits checked while locked; clr wins over a coincident bit.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         bit_cnt <= '0;
      end else if (check_bit && (bit_cnt != 32'hFFFF_FFFF)) begin
         bit_cnt <= bit_cnt + 32'd1;
      end
   end
`else
   assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Purpose: self-checking bench for prbs_checker; directed PRBS-26 scenarios with a scoreboard queue.
// Latency: each stimulus cycle queues the outputs expected after its sampling edge.
// Backpressure: the monitor pops one entry per cycle at the falling edge.
module tb_prbs_checker;

`ifdef PRBS_CHECKER_BITCNT_EN
   localparam bit BITCNT_ON = 1'b1;
`else
   localparam bit BITCNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        din;
   logic        din_valid;
   logic        clr;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [31:0] bit_cnt;

   always #5 clk = ~clk;

   prbs_checker dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .clr       (clr),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .bit_cnt   (bit_cnt)
   );

   typedef struct {
      int          cyc;
      int          sc;
      logic        lock;
      logic        pulse;
      bit          ck_cnt;
      int unsigned err;
      int unsigned bits;
   } exp_t;

   exp_t        sb[$];
   int          cyc     = 0;
   int          n_pass  = 0;
   int          n_total = 0;
   int          sc      = 0;
   logic        e_lock  = 1'b0;
   logic        e_pulse = 1'b0;
   logic [25:0] g;

   // Counts sampling edges so queued expectations can be matched to the right cycle.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int s, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s sc=%0d cyc=%0d got=%0h exp=%0h", nm, s, cyc, act, exp);
   endtask

   // Reference PRBS source: Fibonacci LFSR, output is its last register bit.
   task automatic gen(output logic b);
      b = g[25];
      g = {g[24:0], g[19] ^ g[23] ^ g[24] ^ g[25]};
   endtask

   task automatic step(input logic r, input logic v, input logic d, input logic c,
                       input bit ck, input int unsigned ex_err, input int unsigned ex_bits);
      exp_t e;
      rst       = r;
      din_valid = v;
      din       = d;
      clr       = c;
      e.cyc     = cyc + 1;
      e.sc      = sc;
      e.lock    = e_lock;
      e.pulse   = e_pulse;
      e.ck_cnt  = ck;
      e.err     = ex_err;
      e.bits    = BITCNT_ON ? ex_bits : 0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic good(input int n, input int unsigned ex_err, input int unsigned ex_bits);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step(1'b0, 1'b1, b, 1'b0, (i == n - 1), ex_err, ex_bits);
      end
   endtask

   // Monitor: compare DUT outputs against the expectation queued for this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("locked", e.sc, {31'd0, locked}, {31'd0, e.lock});
            check("err_pulse", e.sc, {31'd0, err_pulse}, {31'd0, e.pulse});
            if (e.ck_cnt) begin
               check("err_cnt", e.sc, {16'd0, err_cnt}, e.err);
               check("bit_cnt", e.sc, bit_cnt, e.bits);
            end
         end
      end
   end

   initial begin
      logic b;
      int   w;
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr = 1'b0;
      g = 26'd1;

      // Reset state
      sc = 1; e_lock = 1'b0; e_pulse = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0);

      // Lock after 26 bits, then 1000 clean bits
      for (int i = 0; i < 26; i++) begin
         gen(b);
         e_lock = (i == 25);
         step(1'b0, 1'b1, b, 1'b0, (i == 25), 0, 0);
      end
      good(1000, 0, 1000);

      // Single inverted bit
      sc = 2;
      gen(b);
      e_pulse = 1'b1;
      step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1, 1001);
      e_pulse = 1'b0;
      good(100, 1, 1101);

      // Gaps with wrong data must be ignored
      sc = 3;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, ~g[25], 1'b0, 1'b1, 1, 1101);
      good(1, 1, 1102);

      // Eight errors within one window drop lock, then relock
      sc = 4;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      for (int i = 0; i < 8; i++) begin
         gen(b);
         e_pulse = 1'b1;
         e_lock  = (i < 7);
         step(1'b0, 1'b1, ~b, 1'b0, 1'b1, i + 1, i + 1);
      end
      e_pulse = 1'b0;
      e_lock  = 1'b0;
      for (int i = 0; i < 26; i++) begin
         gen(b);
         e_lock = (i == 25);
         step(1'b0, 1'b1, b, 1'b0, (i == 25), 8, 8);
      end
      good(30, 8, 38);

      // clr coincident with an error at err_cnt=5
      sc = 5;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         gen(b);
         e_pulse = 1'b1;
         step(1'b0, 1'b1, ~b, 1'b0, 1'b1, k, 2 * k - 1);
         e_pulse = 1'b0;
         gen(b);
         step(1'b0, 1'b1, b, 1'b0, 1'b1, k, 2 * k);
      end
      gen(b);
      e_pulse = 1'b1;
      step(1'b0, 1'b1, ~b, 1'b1, 1'b1, 0, 0);
      e_pulse = 1'b0;
      good(1, 0, 1);

      // rst mid-CHECK with every-other-cycle valid, then gapped relock
      sc = 6;
      for (int i = 0; i < 6; i++) begin
         gen(b);
         step(1'b0, 1'b1, b, 1'b0, 1'b0, 0, 0);
         step(1'b0, 1'b0, ~g[25], 1'b0, (i == 5), 0, 7);
      end
      gen(b);
      e_lock = 1'b0;
      step(1'b1, 1'b1, ~b, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 26; i++) begin
         gen(b);
         e_lock = (i == 25);
         step(1'b0, 1'b1, b, 1'b0, (i == 25), 0, 0);
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      end
      for (int i = 0; i < 20; i++) begin
         gen(b);
         step(1'b0, 1'b1, b, 1'b0, 1'b0, 0, 0);
         step(1'b0, 1'b0, 1'b0, 1'b0, (i == 19), 0, 20);
      end

      // All-zero input never locks
      sc = 7;
      e_lock = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 1'b0, (i == 199), 0, 0);

      din_valid = 1'b0;
      w = 0;
      while (sb.size() > 0 && w < 10) begin
         @(negedge clk);
         #1;
         w++;
      end
      n_total++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain pending=%0d required=0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL provide parameter WIDTH, default 26: PRBS register length.
REQ-002 SHALL provide parameter ERR_W, default 16: error-counter width.
REQ-003 SHALL provide parameter WINDOW, default 64: valid bits per loss-of-lock window.
REQ-004 SHALL provide parameter LOSS_THRESH, default 8: errors per window that force resync.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port din, input, 1: serial bit from upstream LFSR stage (its last register bit).
REQ-008 SHALL have port din_valid, input, 1: din sampled only when high.
REQ-009 SHALL have port clr, input, 1: clears err_cnt and bit_cnt.
REQ-010 SHALL have port locked, output, 1: high while in CHECK.
REQ-011 SHALL have port err_pulse, output, 1: one-cycle mismatch flag.
REQ-012 SHALL have port err_cnt, output, ERR_W: saturating mismatch count.
REQ-013 SHALL have port bit_cnt, output, 32: saturating count of checked bits.

Function
REQ-014 SHALL check the sequence b[n] = b[n-20]^b[n-24]^b[n-25]^b[n-26] (polynomial x^26+x^6+x^2+x+1).
REQ-015 SHALL implement states HUNT and CHECK; rst enters HUNT.
REQ-016 HUNT: each valid bit shifts din into history register hist[WIDTH-1:0]; fill counter increments per valid bit.
REQ-017 HUNT->CHECK on the edge sampling the WIDTH-th valid bit, unless the resulting hist is all-zero; then fill restarts and the state stays HUNT.
REQ-018 CHECK: predicted bit = XOR of hist taps per REQ-014; each valid bit is compared with the prediction; the predicted bit (not din) is shifted into hist.
REQ-019 Mismatch SHALL assert err_pulse on the cycle after the sampling edge for exactly one cycle and increment err_cnt on that edge; err_cnt saturates at all-ones.
REQ-020 bit_cnt SHALL increment per valid bit in CHECK and saturate at 2^32-1.
REQ-021 Window counter SHALL count valid bits in CHECK; at WINDOW bits, window counter and window-error counter reset together.
REQ-022 Window-error count reaching LOSS_THRESH SHALL force CHECK->HUNT on that edge; fill restarts from 0; err_cnt retained.
REQ-023 din_valid low: no state, counter or hist change; err_pulse 0.
REQ-024 clr SHALL take priority over a simultaneous increment: counters become 0 and the coincident error is not counted; err_pulse still fires.
REQ-025 locked SHALL be registered and equal (state==CHECK).

Reset
REQ-026 On rst: state HUNT, hist 0, fill 0, window counters 0, locked 0, err_pulse 0, err_cnt 0, bit_cnt 0.
REQ-027 rst asserted mid-CHECK SHALL discard all progress; relock needs WIDTH fresh valid bits.

Configuration
REQ-028 Macro PRBS_CHECKER_BITCNT_EN: when defined, bit_cnt is implemented per REQ-020; when undefined, bit_cnt SHALL be tied to 0 and no counter logic is built.

Structure
REQ-029 Package prbs_pkg SHALL hold the state enum (HUNT, CHECK), WIDTH default and tap positions (20, 24, 25, 26).
REQ-030 Window/loss-of-lock logic SHALL live in sub-module prbs_lock_mon (inputs: valid-in-CHECK, mismatch; output: lose_lock).

Verification
REQ-031 Reset, then 26 valid bits from an LFSR seeded with 26'b1 -> locked=1 from the cycle after bit 26; err_cnt=0 after 1000 further bits; bit_cnt=1000.
REQ-032 Locked, invert one bit -> err_pulse high one cycle, err_cnt=1, locked stays 1, next 100 bits error-free.
REQ-033 Locked, 8 inverted bits within one 64-bit window -> locked=0 on the edge of the 8th error; correct stream relocks after 26 bits; err_cnt=8.
REQ-034 Constant din=0, 200 valid bits -> locked never asserts.
REQ-035 clr coincident with an error at err_cnt=5 -> err_cnt=0, err_pulse=1.
REQ-036 rst mid-CHECK with din_valid gapped every other cycle -> all outputs 0 next cycle; relock after 26 valid bits.
